// File: rtl/video_symbol_rx_pkg.sv
// Shared definitions for the BT.656 symbol receiver: TRS constants, slice
// classification, framing states and the Gray-code decoder.
package video_pkg;

  localparam logic [7:0] TRS_FF   = 8'hFF;
  localparam logic [7:0] TRS_00   = 8'h00;
  localparam int         XY_H_BIT = 4;

  typedef enum logic [1:0] {
    SL_DATA,
    SL_START,
    SL_END,
    SL_ERR
  } slice_e;

  typedef enum logic {
    FR_IDLE,
    FR_RUN
  } frame_state_e;

  // Callers zero-extend narrower Gray codes; leading zeros decode to zeros.
  function automatic logic [15:0] gray2bin(input logic [15:0] gray);
    logic [15:0] bin;
    bin[15] = gray[15];
    for (int i = 14; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/video_symbol_rx_slicer.sv
// Level slicer: turns one window average into a data symbol, a START/END
// marker or an out-of-range error, registered one cycle after the average.
module symbol_slicer
  import video_pkg::*;
#(
  parameter int LEVEL_BASE      = 64,
  parameter int LEVEL_STEP_LOG2 = 3,
  parameter int SYM_BITS        = 4
) (
  input  logic                clkin,
  input  logic                reset,
  input  logic                avg_valid,
  input  logic [7:0]          avg,
  output logic                slice_valid,
  output slice_e              slice_kind,
  output logic [SYM_BITS-1:0] slice_sym
);

  localparam logic [8:0] BASE9     = 9'(LEVEL_BASE);
  localparam logic [8:0] START_IDX = 9'(1 << SYM_BITS);
  localparam logic [8:0] END_IDX   = 9'((1 << SYM_BITS) + 1);

  logic [8:0]  diff;
  logic [8:0]  idx;
  logic        below_base;
  logic [15:0] gray_in;
  logic [15:0] bin_out;
  slice_e      kind_d;
  logic        unused_bin_msb;

  // Lower bin edge is inclusive: avg == base + k*step lands in bin k.
  always_comb begin
    diff       = {1'b0, avg} - BASE9;
    idx        = diff >> LEVEL_STEP_LOG2;
    below_base = ({1'b0, avg} < BASE9);
    gray_in    = '0;
    gray_in[SYM_BITS-1:0] = idx[SYM_BITS-1:0];
    bin_out    = gray2bin(gray_in);
    if (below_base) begin
      kind_d = SL_ERR;
    end else if (idx < START_IDX) begin
      kind_d = SL_DATA;
    end else if (idx == START_IDX) begin
      kind_d = SL_START;
    end else if (idx == END_IDX) begin
      kind_d = SL_END;
    end else begin
      kind_d = SL_ERR;
    end
  end

  assign unused_bin_msb = ^bin_out[15:SYM_BITS];

  always_ff @(posedge clkin) begin
    if (reset) begin
      slice_valid <= 1'b0;
      slice_kind  <= SL_DATA;
      slice_sym   <= '0;
    end else begin
      slice_valid <= avg_valid;
      if (avg_valid) begin
        slice_kind <= kind_d;
        slice_sym  <= bin_out[SYM_BITS-1:0];
      end
    end
  end

endmodule

// File: rtl/video_symbol_rx.sv
// BT.656 tape-data front end: gates on SAV/EAV, averages OVERSAMPLE active
// bytes per symbol, slices the average and frames data between START/END.
module video_symbol_rx
  import video_pkg::*;
#(
  parameter int OVERSAMPLE      = 4,
  parameter int SYM_BITS        = 4,
  parameter int LEVEL_BASE      = 64,
  parameter int LEVEL_STEP_LOG2 = 3
) (
  input  logic                clkin,
  input  logic                reset,
  input  logic [7:0]          td_in,
  output logic [SYM_BITS-1:0] sym_out,
  output logic                sym_valid,
  output logic                frame_active,
  output logic                frame_done,
  output logic                level_err
);

  localparam int OS_LOG2   = $clog2(OVERSAMPLE);
  localparam int ACC_W     = 8 + OS_LOG2;
  localparam int TOP_LEVEL = LEVEL_BASE + (((1 << SYM_BITS) + 2) << LEVEL_STEP_LOG2);
  localparam logic [OS_LOG2-1:0] CNT_LAST = OS_LOG2'(OVERSAMPLE - 1);

  if (OVERSAMPLE < 2 || OVERSAMPLE > 16 || (OVERSAMPLE & (OVERSAMPLE - 1)) != 0) begin : g_bad_oversample
    $error("video_symbol_rx: OVERSAMPLE must be a power of 2 in 2..16");
  end

  if (TOP_LEVEL > 255) begin : g_bad_levels
    $error("video_symbol_rx: marker bins exceed the 8-bit level range");
  end

  logic [7:0]         hist0;
  logic [7:0]         hist1;
  logic [7:0]         hist2;
  logic               active;
  logic [OS_LOG2-1:0] win_count;
  logic [ACC_W-1:0]   acc;
  logic               avg_valid;
  logic [7:0]         avg;

  logic               is_xy;
  logic               count_byte;
  logic               win_last;
  logic [ACC_W-1:0]   sum_next;
  logic [ACC_W-1:0]   sum_shift;
  logic               unused_sum_msb;

  // hist2 is the oldest byte, so FF,00,00 in history marks the current byte as XY.
  always_comb begin
    is_xy      = (hist2 == TRS_FF) && (hist1 == TRS_00) && (hist0 == TRS_00);
    count_byte = active && (td_in != TRS_00) && (td_in != TRS_FF) && !is_xy;
    win_last   = count_byte && (win_count == CNT_LAST);
    sum_next   = acc + ACC_W'(td_in);
    sum_shift  = sum_next >> OS_LOG2;
  end

  assign unused_sum_msb = ^sum_shift[ACC_W-1:8];

  // Any timing reference drops a partial window so symbols never straddle a TRS.
  always_ff @(posedge clkin) begin
    if (reset) begin
      hist0     <= '0;
      hist1     <= '0;
      hist2     <= '0;
      active    <= 1'b0;
      win_count <= '0;
      acc       <= '0;
      avg_valid <= 1'b0;
      avg       <= '0;
    end else begin
      hist2     <= hist1;
      hist1     <= hist0;
      hist0     <= td_in;
      avg_valid <= 1'b0;
      if (is_xy) begin
        active    <= ~td_in[XY_H_BIT];
        win_count <= '0;
        acc       <= '0;
      end else if (count_byte) begin
        if (win_last) begin
          avg       <= sum_shift[7:0];
          avg_valid <= 1'b1;
          win_count <= '0;
          acc       <= '0;
        end else begin
          win_count <= win_count + 1'b1;
          acc       <= sum_next;
        end
      end
    end
  end

  logic                slice_valid;
  slice_e              slice_kind;
  logic [SYM_BITS-1:0] slice_sym;

  symbol_slicer #(
    .LEVEL_BASE      (LEVEL_BASE),
    .LEVEL_STEP_LOG2 (LEVEL_STEP_LOG2),
    .SYM_BITS        (SYM_BITS)
  ) u_slicer (
    .clkin       (clkin),
    .reset       (reset),
    .avg_valid   (avg_valid),
    .avg         (avg),
    .slice_valid (slice_valid),
    .slice_kind  (slice_kind),
    .slice_sym   (slice_sym)
  );

  frame_state_e        state;
  frame_state_e        state_next;
  logic [SYM_BITS-1:0] sym_out_d;
  logic                sym_valid_d;
  logic                frame_done_d;
  logic                level_err_d;

  always_ff @(posedge clkin) begin
    if (reset) begin
      state      <= FR_IDLE;
      sym_out    <= '0;
      sym_valid  <= 1'b0;
      frame_done <= 1'b0;
      level_err  <= 1'b0;
    end else begin
      state      <= state_next;
      sym_out    <= sym_out_d;
      sym_valid  <= sym_valid_d;
      frame_done <= frame_done_d;
      level_err  <= level_err_d;
    end
  end

  // Only markers move the frame; EAV/SAV never end a frame on their own.
  always_comb begin
    state_next = state;
    if (slice_valid) begin
      case (state)
        FR_IDLE: if (slice_kind == SL_START) state_next = FR_RUN;
        FR_RUN:  if (slice_kind == SL_END)   state_next = FR_IDLE;
        default: state_next = FR_IDLE;
      endcase
    end
  end

  always_comb begin
    sym_out_d    = sym_out;
    sym_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    level_err_d  = 1'b0;
    if (slice_valid) begin
      case (slice_kind)
        SL_DATA: begin
          if (state == FR_RUN) begin
            sym_out_d   = slice_sym;
            sym_valid_d = 1'b1;
          end
        end
        SL_END:   frame_done_d = (state == FR_RUN);
        SL_ERR:   level_err_d  = 1'b1;
        default:  sym_valid_d  = 1'b0;
      endcase
    end
  end

  assign frame_active = (state == FR_RUN);

endmodule

// File: tb/tb_video_symbol_rx.sv
// Scoreboard bench for video_symbol_rx: a byte-level reference model queues
// expected output events; a negedge monitor pops and compares them.
module tb_video_symbol_rx;

  localparam int OS   = 4;
  localparam int BASE = 64;
  localparam int STEP = 8;
  localparam int NLEV = 16;

  logic       clkin = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] td_in = 8'h00;
  logic [3:0] sym_out;
  logic       sym_valid;
  logic       frame_active;
  logic       frame_done;
  logic       level_err;

  video_symbol_rx #(
    .OVERSAMPLE      (4),
    .SYM_BITS        (4),
    .LEVEL_BASE      (64),
    .LEVEL_STEP_LOG2 (3)
  ) dut (
    .clkin        (clkin),
    .reset        (reset),
    .td_in        (td_in),
    .sym_out      (sym_out),
    .sym_valid    (sym_valid),
    .frame_active (frame_active),
    .frame_done   (frame_done),
    .level_err    (level_err)
  );

  always #5 clkin = ~clkin;

  int cyc = 0;
  always @(posedge clkin) cyc <= cyc + 1;

  // flags = {sym_valid, frame_done, level_err}
  typedef struct {
    int         cyc;
    logic [2:0] flags;
    int         sym;
  } exp_t;

  exp_t exp_q[$];
  bit   fa_sched[int];
  bit   exp_fa  = 1'b0;
  bit   mon_off = 1'b1;
  int   checks  = 0;
  int   errors  = 0;

  int   m_hist[$];
  int   m_win[$];
  bit   m_active;
  bit   m_in_frame;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  function automatic int gray_decode(input int g);
    for (int b = 0; b < NLEV; b++) begin
      if ((b ^ (b >> 1)) == g) return b;
    end
    return -1;
  endfunction

  task automatic model_clear();
    m_hist = '{0, 0, 0};
    m_win.delete();
    m_active   = 1'b0;
    m_in_frame = 1'b0;
    exp_q.delete();
    fa_sched.delete();
    exp_fa = 1'b0;
  endtask

  task automatic push_event(input int c, input logic [2:0] f, input int s);
    exp_t e;
    e.cyc   = c;
    e.flags = f;
    e.sym   = s;
    exp_q.push_back(e);
  endtask

  // Classify a window average and advance the frame model; outputs land two edges later.
  task automatic model_slice(input int avg, input int k);
    int idx;
    int kind;
    int sym;
    sym = 0;
    if (avg < BASE) kind = 3;
    else begin
      idx = (avg - BASE) / STEP;
      if (idx < NLEV) begin
        kind = 0;
        sym  = gray_decode(idx);
      end else if (idx == NLEV) kind = 1;
      else if (idx == NLEV + 1) kind = 2;
      else kind = 3;
    end
    if (!m_in_frame) begin
      if (kind == 1) begin
        m_in_frame = 1'b1;
        fa_sched[k + 2] = 1'b1;
      end else if (kind == 3) push_event(k + 2, 3'b001, 0);
    end else begin
      if (kind == 0) push_event(k + 2, 3'b100, sym);
      else if (kind == 2) begin
        m_in_frame = 1'b0;
        fa_sched[k + 2] = 1'b0;
        push_event(k + 2, 3'b010, 0);
      end else if (kind == 3) push_event(k + 2, 3'b001, 0);
    end
  endtask

  task automatic model_byte(input int b, input int k);
    int sum;
    if (m_hist[0] == 255 && m_hist[1] == 0 && m_hist[2] == 0) begin
      m_active = ((b & 16) == 0);
      m_win.delete();
    end else if (m_active && b != 0 && b != 255) begin
      m_win.push_back(b);
      if (m_win.size() == OS) begin
        sum = 0;
        foreach (m_win[i]) sum += m_win[i];
        m_win.delete();
        model_slice(sum / OS, k);
      end
    end
    m_hist.push_back(b);
    void'(m_hist.pop_front());
  endtask

  task automatic applyStimulus(input int b);
    @(negedge clkin);
    td_in = 8'(b);
    model_byte(b, cyc + 1);
  endtask

  task automatic sendTrs(input bit sav);
    applyStimulus(255);
    applyStimulus(0);
    applyStimulus(0);
    applyStimulus(sav ? 8'h80 : 8'h9D);
  endtask

  task automatic sendWindow(input int a, input int b, input int c, input int d);
    applyStimulus(a);
    applyStimulus(b);
    applyStimulus(c);
    applyStimulus(d);
  endtask

  task automatic sendLevel(input int v);
    sendWindow(v, v, v, v);
  endtask

  task automatic applyReset(input int n);
    @(negedge clkin);
    mon_off = 1'b1;
    reset   = 1'b1;
    td_in   = 8'h00;
    model_clear();
    repeat (n) @(negedge clkin);
    checkOutput("reset_sym_out", int'(sym_out), 0);
    checkOutput("reset_sym_valid", int'(sym_valid), 0);
    checkOutput("reset_frame_active", int'(frame_active), 0);
    checkOutput("reset_frame_done", int'(frame_done), 0);
    checkOutput("reset_level_err", int'(level_err), 0);
    reset   = 1'b0;
    mon_off = 1'b0;
  endtask

  exp_t mon_e;

  always @(negedge clkin) begin
    if (!mon_off && !reset) begin
      if (fa_sched.exists(cyc)) begin
        exp_fa = fa_sched[cyc];
        fa_sched.delete(cyc);
      end
      checkOutput("frame_active", int'(frame_active), int'(exp_fa));
      if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        mon_e = exp_q.pop_front();
        checks++;
        errors++;
        $display("[TB] FAIL missed_event: got no output, expected flags %b at cycle %0d", mon_e.flags, mon_e.cyc);
      end
      if (sym_valid || frame_done || level_err) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_event: got flags %b, expected none (cycle %0d)",
                   {sym_valid, frame_done, level_err}, cyc);
        end else begin
          mon_e = exp_q.pop_front();
          checkOutput("event_cycle", cyc, mon_e.cyc);
          checkOutput("event_flags", int'({sym_valid, frame_done, level_err}), int'(mon_e.flags));
          if (mon_e.flags == 3'b100) checkOutput("sym_out", int'(sym_out), mon_e.sym);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int center;
    int r;
    int v[4];
    model_clear();
    applyReset(2);

    sendTrs(1'b1);
    sendLevel(180);
    sendLevel(195);
    sendLevel(100);
    sendLevel(203);

    sendTrs(1'b1);
    sendLevel(195);
    sendLevel(50);
    sendLevel(230);
    sendLevel(100);
    sendLevel(64);
    sendLevel(191);
    sendLevel(192);
    sendLevel(207);

    sendTrs(1'b1);
    sendLevel(195);
    sendWindow(100, 101, 102, 104);
    applyStimulus(100);
    applyStimulus(100);
    sendTrs(1'b0);
    sendTrs(1'b1);
    sendLevel(120);
    sendLevel(203);

    sendTrs(1'b1);
    sendLevel(195);
    sendLevel(100);
    sendLevel(130);
    applyReset(1);
    sendTrs(1'b1);
    sendLevel(100);
    sendLevel(195);
    sendLevel(64);
    sendLevel(207);

    for (int it = 0; it < 200; it++) begin
      r = int'($urandom_range(0, 11));
      if (r == 0) sendTrs(1'b1);
      else if (r == 1) sendTrs(1'b0);
      else if (r == 2) applyStimulus(0);
      else if (r == 3) applyStimulus(255);
      else begin
        if (r == 4) center = 196;
        else if (r == 5) center = 203;
        else center = int'($urandom_range(30, 240));
        for (int j = 0; j < 4; j++) begin
          v[j] = center + int'($urandom_range(0, 6)) - 3;
          if (v[j] < 1) v[j] = 1;
          if (v[j] > 254) v[j] = 254;
        end
        sendWindow(v[0], v[1], v[2], v[3]);
      end
    end

    repeat (6) applyStimulus(0);
    checkOutput("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
